// File: rtl/riscv_wb_pkg.sv
// Shared widths, default queue depth and the queued write-back entry type
// for the register-bank write-back stage.
package riscv_wb_pkg;

   localparam int XLEN          = 32;
   localparam int REG_ADDR_W    = 5;
   localparam int DEFAULT_DEPTH = 4;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Execute/memory-side request signals, decode hazard query and the
// register-bank write port of the write-back stage.
interface writeback_arbiter_if;
   import riscv_wb_pkg::*;

   logic                  alu_valid;
   logic [REG_ADDR_W-1:0] alu_rd;
   logic [XLEN-1:0]       alu_data;
   logic                  load_issue;
   logic [REG_ADDR_W-1:0] load_issue_rd;
   logic                  mem_valid;
   logic [XLEN-1:0]       mem_data;
   logic [REG_ADDR_W-1:0] rs1;
   logic [REG_ADDR_W-1:0] rs2;
   logic                  full;
   logic                  load_busy;
   logic                  hazard_rs1;
   logic                  hazard_rs2;
   logic                  RegWrite;
   logic [REG_ADDR_W-1:0] rd;
   logic [XLEN-1:0]       Write_Data;

   modport slave (
      input  alu_valid, alu_rd, alu_data, load_issue, load_issue_rd,
             mem_valid, mem_data, rs1, rs2,
      output full, load_busy, hazard_rs1, hazard_rs2, RegWrite, rd, Write_Data
   );

   modport master (
      output alu_valid, alu_rd, alu_data, load_issue, load_issue_rd,
             mem_valid, mem_data, rs1, rs2,
      input  full, load_busy, hazard_rs1, hazard_rs2, RegWrite, rd, Write_Data
   );

endinterface

// File: rtl/wb_fifo.sv
// Two-write/one-read circular queue of write-back entries; drains one entry
// per cycle and exposes every occupied destination for hazard comparison.
module wb_fifo
   import riscv_wb_pkg::*;
#(
   parameter  int DEPTH = DEFAULT_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 wr0_en,
   input  wb_entry_t                            wr0_entry,
   input  logic                                 wr1_en,
   input  wb_entry_t                            wr1_entry,
   output logic [CNT_W-1:0]                     count,
   output wb_entry_t                            head,
   output logic [DEPTH-1:0]                     occ_valid,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]     occ_rd
);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr1_ptr;
   logic [CNT_W-1:0] n_enq;
   logic             deq;

   assign deq     = (count != '0);
   assign n_enq   = CNT_W'(wr0_en) + CNT_W'(wr1_en);
   // The second write lands behind the first only when the first is present.
   assign wr1_ptr = wr_ptr + PTR_W'(wr0_en);

   // NOTE: clocked state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         count  <= count + n_enq - CNT_W'(deq);
         wr_ptr <= wr_ptr + PTR_W'(n_enq);
         rd_ptr <= rd_ptr + PTR_W'(deq);
      end
   end

   // NOTE: storage is not reset; count alone decides which slots hold data.
   always_ff @(posedge clk) begin
      if (wr0_en) mem[wr_ptr]  <= wr0_entry;
      if (wr1_en) mem[wr1_ptr] <= wr1_entry;
   end

   assign head = mem[rd_ptr];

   // NOTE: outputs get a default before the loop so no path infers a latch.
   always_comb begin
      logic [PTR_W-1:0] off;
      occ_valid = '0;
      occ_rd    = '0;
      off       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off          = PTR_W'(i) - rd_ptr;
         occ_valid[i] = (CNT_W'(off) < count);
         occ_rd[i]    = mem[i].rd;
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Write-back stage: merges ALU results and single-outstanding load responses
// into the register-bank write port and flags decode operand hazards.
module writeback_arbiter
   import riscv_wb_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input logic                 clk,
   input logic                 reset,
   writeback_arbiter_if.slave  wb
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                             load_busy;
   logic [REG_ADDR_W-1:0]            load_rd;
   logic                             mem_accept;
   logic                             full;
   logic                             wr0_en;
   logic                             wr1_en;
   wb_entry_t                        wr0_entry;
   wb_entry_t                        wr1_entry;
   logic [CNT_W-1:0]                 count;
   wb_entry_t                        head;
   logic [DEPTH-1:0]                 occ_valid;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] occ_rd;
   logic                             hit_rs1;
   logic                             hit_rs2;

   assign mem_accept = wb.mem_valid && load_busy;
   // Registered count leaves room for one load plus one ALU result.
   assign full       = (count > CNT_W'(DEPTH - 2));

   // Load response first so a same-rd ALU result retires after it.
   assign wr0_en    = mem_accept && (load_rd != '0);
   assign wr0_entry = '{rd: load_rd, data: wb.mem_data};
   assign wr1_en    = wb.alu_valid && !full && (wb.alu_rd != '0);
   assign wr1_entry = '{rd: wb.alu_rd, data: wb.alu_data};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load_busy <= 1'b0;
         load_rd   <= '0;
      end else if (wb.load_issue && (!load_busy || mem_accept)) begin
         load_busy <= 1'b1;
         load_rd   <= wb.load_issue_rd;
      end else if (mem_accept) begin
         load_busy <= 1'b0;
      end
   end

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr0_en    (wr0_en),
      .wr0_entry (wr0_entry),
      .wr1_en    (wr1_en),
      .wr1_entry (wr1_entry),
      .count     (count),
      .head      (head),
      .occ_valid (occ_valid),
      .occ_rd    (occ_rd)
   );

   always_comb begin
      hit_rs1 = load_busy && (load_rd == wb.rs1);
      hit_rs2 = load_busy && (load_rd == wb.rs2);
      for (int i = 0; i < DEPTH; i++) begin
         if (occ_valid[i] && (occ_rd[i] == wb.rs1)) hit_rs1 = 1'b1;
         if (occ_valid[i] && (occ_rd[i] == wb.rs2)) hit_rs2 = 1'b1;
      end
   end

   assign wb.hazard_rs1 = (wb.rs1 != '0) && hit_rs1;
   assign wb.hazard_rs2 = (wb.rs2 != '0) && hit_rs2;
   assign wb.full       = full;
   assign wb.load_busy  = load_busy;
   assign wb.RegWrite   = (count != '0);
   assign wb.rd         = wb.RegWrite ? head.rd   : '0;
   assign wb.Write_Data = wb.RegWrite ? head.data : '0;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus random traffic, all
// compared against a queue-based reference model of the write-back rules.
module tb_writeback_arbiter;

   localparam int DEPTH = 4;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   bit   saw_full;

   ent_t       mq[$];
   bit         m_busy;
   logic [4:0] m_lrd;

   writeback_arbiter_if wbif ();

   writeback_arbiter #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .wb    (wbif.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit model_hazard(input logic [4:0] rs);
      bit h;
      h = m_busy && (m_lrd == rs);
      foreach (mq[i]) if (mq[i].rd == rs) h = 1'b1;
      return (rs != 5'd0) && h;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_busy = 1'b0;
      m_lrd  = 5'd0;
   endtask

   // One clock edge of the write-back rules, applied to the model queue.
   task automatic model_step();
      bit was_full;
      was_full = (mq.size() > DEPTH - 2);
      if (mq.size() > 0) void'(mq.pop_front());
      if (wbif.mem_valid && m_busy && m_lrd != 5'd0)
         mq.push_back('{rd: m_lrd, data: wbif.mem_data});
      if (wbif.alu_valid && !was_full && wbif.alu_rd != 5'd0)
         mq.push_back('{rd: wbif.alu_rd, data: wbif.alu_data});
      if (m_busy && wbif.mem_valid) begin
         if (wbif.load_issue) m_lrd = wbif.load_issue_rd;
         else                 m_busy = 1'b0;
      end else if (!m_busy && wbif.load_issue) begin
         m_busy = 1'b1;
         m_lrd  = wbif.load_issue_rd;
      end
   endtask

   task automatic compare_all(input string tag);
      bit exp_we;
      exp_we = (mq.size() > 0);
      check({tag, ".we"},   wbif.RegWrite,   exp_we);
      check({tag, ".rd"},   wbif.rd,         exp_we ? mq[0].rd : 5'd0);
      check({tag, ".data"}, wbif.Write_Data, exp_we ? mq[0].data : 32'd0);
      check({tag, ".full"}, wbif.full,       mq.size() > DEPTH - 2);
      check({tag, ".busy"}, wbif.load_busy,  m_busy);
      check({tag, ".hz1"},  wbif.hazard_rs1, model_hazard(wbif.rs1));
      check({tag, ".hz2"},  wbif.hazard_rs2, model_hazard(wbif.rs2));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all(tag);
   endtask

   task automatic idle_inputs();
      wbif.alu_valid     = 1'b0;
      wbif.alu_rd        = 5'd0;
      wbif.alu_data      = 32'd0;
      wbif.load_issue    = 1'b0;
      wbif.load_issue_rd = 5'd0;
      wbif.mem_valid     = 1'b0;
      wbif.mem_data      = 32'd0;
   endtask

   initial begin
      reset     = 1'b0;
      saw_full  = 1'b0;
      wbif.rs1  = 5'd0;
      wbif.rs2  = 5'd0;
      idle_inputs();
      model_reset();
      @(negedge clk);
      compare_all("reset");
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) step("idle");
      check("idle.we_const", wbif.RegWrite, 1'b0);

      // Single ALU write with hazard on rs1 for exactly one cycle.
      wbif.rs1 = 5'd5;
      wbif.alu_valid = 1'b1; wbif.alu_rd = 5'd5; wbif.alu_data = 32'hDEADBEEF;
      step("alu1");
      check("alu1.rd_const",   wbif.rd, 5'd5);
      check("alu1.data_const", wbif.Write_Data, 32'hDEADBEEF);
      check("alu1.hz_const",   wbif.hazard_rs1, 1'b1);
      idle_inputs();
      step("alu1_after");
      check("alu1_after.we_const", wbif.RegWrite, 1'b0);
      check("alu1_after.hz_const", wbif.hazard_rs1, 1'b0);

      // Load response and ALU to the same rd in one cycle.
      wbif.rs2 = 5'd7;
      wbif.load_issue = 1'b1; wbif.load_issue_rd = 5'd7;
      step("ld7_issue");
      check("ld7_issue.hz_const", wbif.hazard_rs2, 1'b1);
      idle_inputs();
      step("ld7_wait");
      wbif.mem_valid = 1'b1; wbif.mem_data = 32'h11;
      wbif.alu_valid = 1'b1; wbif.alu_rd = 5'd7; wbif.alu_data = 32'h22;
      step("ld7_both");
      check("ld7_first.data_const", wbif.Write_Data, 32'h11);
      idle_inputs();
      step("ld7_second");
      check("ld7_second.data_const", wbif.Write_Data, 32'h22);
      check("ld7_second.hz_const",   wbif.hazard_rs2, 1'b1);
      step("ld7_done");

      // x0 filtering and back-to-back loads.
      wbif.rs1 = 5'd4; wbif.rs2 = 5'd3;
      wbif.alu_valid = 1'b1; wbif.alu_rd = 5'd0; wbif.alu_data = 32'h99;
      step("x0_alu");
      check("x0_alu.we_const", wbif.RegWrite, 1'b0);
      idle_inputs();
      wbif.load_issue = 1'b1; wbif.load_issue_rd = 5'd3;
      step("ld3_issue");
      wbif.mem_valid = 1'b1; wbif.mem_data = 32'h33;
      wbif.load_issue_rd = 5'd4;
      step("b2b");
      check("b2b.busy_const", wbif.load_busy, 1'b1);
      check("b2b.rd_const",   wbif.rd, 5'd3);
      idle_inputs();
      step("b2b_wait");
      wbif.mem_valid = 1'b1; wbif.mem_data = 32'h44;
      step("ld4_resp");
      check("ld4_resp.rd_const",   wbif.rd, 5'd4);
      check("ld4_resp.data_const", wbif.Write_Data, 32'h44);
      idle_inputs();
      step("ld4_done");

      // Streamed ALU writes wrap the pointers without reaching full.
      for (int r = 1; r <= 12; r++) begin
         wbif.alu_valid = 1'b1; wbif.alu_rd = 5'(r); wbif.alu_data = 32'(r * 16);
         step("stream");
         check("stream.full_const", wbif.full, 1'b0);
      end
      idle_inputs();
      step("stream_drain");
      step("stream_drain");

      // Load response plus ALU each cycle fills the queue.
      for (int c = 0; c < 10; c++) begin
         wbif.load_issue    = 1'b1;
         wbif.load_issue_rd = 5'($urandom_range(31, 1));
         wbif.mem_valid     = 1'b1;
         wbif.mem_data      = $urandom;
         wbif.alu_valid     = !(mq.size() > DEPTH - 2);
         wbif.alu_rd        = 5'($urandom_range(31, 1));
         wbif.alu_data      = $urandom;
         step("fill");
         if (wbif.full) saw_full = 1'b1;
      end
      check("fill.saw_full", saw_full, 1'b1);
      idle_inputs();
      for (int c = 0; c < 5; c++) step("fill_drain");

      // Reset mid-operation with three entries queued.
      wbif.load_issue = 1'b1; wbif.load_issue_rd = 5'd9;
      step("rst_fill");
      for (int c = 0; c < 2; c++) begin
         wbif.mem_valid = 1'b1; wbif.mem_data = 32'hA0 + 32'(c);
         wbif.alu_valid = 1'b1; wbif.alu_rd = 5'd10 + 5'(c); wbif.alu_data = 32'hB0 + 32'(c);
         step("rst_fill");
      end
      check("rst_fill.full_const", wbif.full, 1'b1);
      idle_inputs();
      wbif.load_issue = 1'b1; wbif.load_issue_rd = 5'd12;
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      compare_all("rst_mid");
      check("rst_mid.we_const", wbif.RegWrite, 1'b0);
      @(negedge clk);
      compare_all("rst_hold");
      idle_inputs();
      reset = 1'b1;
      wbif.mem_valid = 1'b1; wbif.mem_data = 32'hBAD;
      step("rst_stale");
      check("rst_stale.we_const", wbif.RegWrite, 1'b0);
      idle_inputs();
      step("rst_after");

      // Random traffic, occasionally violating the full protocol.
      for (int c = 0; c < 400; c++) begin
         wbif.rs1           = 5'($urandom_range(7, 0));
         wbif.rs2           = 5'($urandom_range(7, 0));
         wbif.alu_rd        = 5'($urandom_range(7, 0));
         wbif.alu_data      = $urandom;
         wbif.alu_valid     = ($urandom_range(1, 0) == 1) &&
                              (!(mq.size() > DEPTH - 2) || $urandom_range(9, 0) == 0);
         wbif.load_issue    = ($urandom_range(2, 0) == 0);
         wbif.load_issue_rd = 5'($urandom_range(7, 0));
         wbif.mem_valid     = ($urandom_range(2, 0) == 0);
         wbif.mem_data      = $urandom;
         step("rand");
      end
      idle_inputs();
      for (int c = 0; c < 6; c++) step("final_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Write-back stage driving the single write port (RegWrite, rd, Write_Data) of the 32x32 register bank.
- Merges single-cycle ALU results with asynchronous load responses from data memory through a small 2-write/1-read queue.
- Provides per-operand hazard flags so decode stalls while a destination register has an unretired write.
- Sits between execute/memory and the register bank. The bank has no internal bypass.

Parameters:
- XLEN, 32, data width.
- REG_ADDR_W, 5, register index width.
- DEPTH, 4, queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  REG_ADDR_W  ALU destination.
- alu_data  in  XLEN  ALU result.
- load_issue  in  1  load issued this cycle.
- load_issue_rd  in  REG_ADDR_W  load destination.
- mem_valid  in  1  load data returned this cycle.
- mem_data  in  XLEN  load data.
- rs1, rs2  in  REG_ADDR_W  decode operand indices for hazard query.
- full  out  1  queue cannot take two more entries; upstream holds alu_valid low.
- load_busy  out  1  one load outstanding.
- hazard_rs1, hazard_rs2  out  1  operand has a pending write.
- RegWrite  out  1  write enable to register bank.
- rd  out  REG_ADDR_W  write address.
- Write_Data  out  XLEN  write data.

Behaviour:
- Reset (reset=0, async): count=0, pointers=0, load_busy=0, load_rd=0. RegWrite=0, rd=0, Write_Data=0, full=0, hazards=0.
- Queue: holds DEPTH {rd,data} entries. Pointers wrap mod DEPTH. Count width is clog2(DEPTH+1).
- Enqueue, per edge, in this order:
  - load response (mem_valid && load_busy) as {load_rd, mem_data};
  - then ALU (alu_valid) as {alu_rd, alu_data}.
  - This order keeps the younger ALU value last when both target the same rd.
- x0 filtering: entries with rd==0 are dropped and never enqueued. A load issued to x0 still sets load_busy, but its response is dropped.
- Dequeue: one entry per edge whenever count>0, simultaneous with up to two enqueues. Next count = count + enq - deq.
- Outputs: combinational from the head entry. RegWrite = (count>0); rd/Write_Data = head when RegWrite=1, else 0.
- Latency, empty queue: alu_valid sampled at edge k gives RegWrite=1 after edge k; the bank writes at edge k+1. Throughput is 1 write/cycle.
- full = (count > DEPTH-2). Evaluating from the registered count guarantees room for one load plus one ALU result.
- Upstream asserting alu_valid while full=1 is a protocol violation. The ALU entry is dropped; no corruption of existing entries.
- Load tracking (single outstanding):
  - load_issue with load_busy=0: set load_busy, load_rd=load_issue_rd.
  - mem_valid with load_busy=1: enqueue the response, clear load_busy.
  - Both in the same cycle (back-to-back): enqueue the response for the old load_rd, then capture the new load_rd; load_busy stays 1.
  - load_issue while busy without mem_valid: ignored; upstream must stall on load_busy.
  - mem_valid with load_busy=0: ignored.
- Hazard (combinational): hazard_rsN = rsN!=0 && ((load_busy && load_rd==rsN) || any occupied entry with rd==rsN).
- Reset mid-operation: queued writes are discarded and never reach the bank. An in-flight mem_valid arriving after reset release is ignored.

Decomposition:
- Package riscv_wb_pkg: XLEN, REG_ADDR_W, DEPTH defaults, and typedef wb_entry_t {rd, data}.
- Sub-module wb_fifo: 2-write/1-read circular queue exposing count, head, and a per-entry occupied-rd vector for hazard compare.
- writeback_arbiter keeps load tracking, x0 filtering, full, and hazard logic.

Test Plan:
- Reset then idle: reset=0 mid-cycle -> all outputs 0 immediately. After release with no stimulus, RegWrite stays 0.
- Single ALU: alu_valid, alu_rd=5, alu_data=0xDEADBEEF at edge k -> RegWrite=1, rd=5, Write_Data=0xDEADBEEF for exactly one cycle after edge k. hazard_rs1=1 for rs1=5 during that cycle only.
- Simultaneous load and ALU to same rd:
  - Stimulus: load_issue rd=7; later mem_valid data=0x11 in the same cycle as alu_valid rd=7 data=0x22.
  - Required: writes rd=7/0x11, then rd=7/0x22 on consecutive cycles. hazard_rs2 (rs2=7) stays high from issue until the second write.
- x0 and back-to-back loads:
  - Stimulus: alu_rd=0 -> no write. Load to x3 with mem_valid and load_issue rd=4 in the same cycle, then mem_valid data=0x44.
  - Required: writes x3 then x4/0x44; load_busy remains 1 across the overlap.
- Full/wrap: drive alu_valid every cycle while sampling full, rd=1..12, data=rd*0x10 -> full never asserted (drain rate equals fill rate). Then inject a load response each cycle too -> full=1 when count>2. Every accepted entry is written in order, with pointers wrapped at least twice.
- Reset mid-operation: fill 3 entries, assert reset=0, then release -> no stale RegWrite. A mem_valid arriving after release is ignored.
